// File: rtl/stack_call_ctrl_pkg.sv
// stack_call_ctrl_pkg: shared widths, limits and encodings for the return-stack sequencer.
package stack_call_ctrl_pkg;
    localparam int ADDR_W = 13;
    localparam int DEPTH_MAX = 1023;
    typedef enum logic [1:0] {FC_NONE = 2'b00, FC_OVF = 2'b01, FC_UNF = 2'b10, FC_DESYNC = 2'b11} fault_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_FAULT} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_CALL, OP_RET, OP_IRQ} op_e;
    function automatic logic is_push(op_e op);
        return op == OP_CALL || op == OP_IRQ;
    endfunction
endpackage

// File: rtl/stack_req_arbiter.sv
// stack_req_arbiter: pending flags, operand latches and Irq > Call > Ret grant.
module stack_req_arbiter
    import stack_call_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              call_req,
    input  logic [ADDR_W-1:0] call_nppc,
    input  logic              ret_req,
    input  logic              ret_is_iret,
    input  logic              irq_req,
    input  logic [ADDR_W-1:0] irq_pc,
    input  logic              grant_en,
    input  logic              irq_active,
    input  logic              clr,
    output op_e               grant,
    output logic [ADDR_W-1:0] call_addr,
    output logic [ADDR_W-1:0] irq_addr,
    output logic              ret_iret,
    output logic              pending
);
    logic pend_call, pend_ret, pend_irq;

    // A pending irq is masked, not dropped, while the handler is running.
    assign grant = !grant_en ? OP_NONE :
                   (pend_irq && !irq_active) ? OP_IRQ :
                   pend_call ? OP_CALL :
                   pend_ret ? OP_RET : OP_NONE;
    assign pending = pend_call | pend_ret | pend_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_call <= 1'b0;
            pend_ret  <= 1'b0;
            pend_irq  <= 1'b0;
            call_addr <= '0;
            irq_addr  <= '0;
            ret_iret  <= 1'b0;
        end else if (clr) begin
            pend_call <= 1'b0;
            pend_ret  <= 1'b0;
            pend_irq  <= 1'b0;
        end else begin
            pend_call <= pend_call ? grant != OP_CALL : call_req;
            pend_ret  <= pend_ret ? grant != OP_RET : ret_req;
            pend_irq  <= pend_irq ? grant != OP_IRQ : irq_req;
            if (call_req && !pend_call) call_addr <= call_nppc;
            if (ret_req && !pend_ret) ret_iret <= ret_is_iret;
            if (irq_req && !pend_irq) irq_addr <= irq_pc;
        end
    end
endmodule

// File: rtl/stack_call_ctrl.sv
// stack_call_ctrl: serialises call/return/interrupt requests into single stack push/pop
// operations, tracking a shadow depth so over/underflow is caught before the stack is driven.
module stack_call_ctrl
    import stack_call_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IRQ_VECTOR = 13'h0010
) (
    input  logic              Slow_Clock,
    input  logic              Reset,
    input  logic              Call_Req,
    input  logic [ADDR_W-1:0] Call_NPPC,
    input  logic              Ret_Req,
    input  logic              Ret_Is_Iret,
    input  logic              Irq_Req,
    input  logic [ADDR_W-1:0] Irq_PC,
    input  logic              Fault_Clr,
    output logic              Stack_Enable,
    output logic              Stack_Write,
    output logic [ADDR_W-1:0] NPPC,
    input  logic [ADDR_W-1:0] Ret_Add,
    input  logic              Err_Out,
    output logic              Call_Ack,
    output logic              Ret_Ack,
    output logic              Irq_Ack,
    output logic              Op_Err,
    output logic              Jump_Valid,
    output logic [ADDR_W-1:0] Jump_Addr,
    output logic [9:0]        Depth,
    output logic              Irq_Active,
    output logic              Busy,
    output logic              Fault,
    output logic [1:0]        Fault_Code
);
    state_e            state, state_n;
    op_e               grant, op;
    fault_e            code;
    logic [ADDR_W-1:0] call_addr, irq_addr, ret_q;
    logic              ret_iret, iret_q, pending, pre_fail, ok;

    stack_req_arbiter u_arb (
        .clk        (Slow_Clock),
        .rst_n      (Reset),
        .call_req   (Call_Req),
        .call_nppc  (Call_NPPC),
        .ret_req    (Ret_Req),
        .ret_is_iret(Ret_Is_Iret),
        .irq_req    (Irq_Req),
        .irq_pc     (Irq_PC),
        .grant_en   (state == S_IDLE),
        .irq_active (Irq_Active),
        .clr        (state == S_FAULT && Fault_Clr),
        .grant      (grant),
        .call_addr  (call_addr),
        .irq_addr   (irq_addr),
        .ret_iret   (ret_iret),
        .pending    (pending)
    );

    assign Busy       = state != S_IDLE || pending;
    assign Fault      = state == S_FAULT;
    assign Fault_Code = code;

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        pre_fail = is_push(grant) ? Depth == 10'(DEPTH_MAX) : grant == OP_RET && Depth == '0;
        ok       = state == S_CAPTURE && code == FC_NONE;
        state_n  = state == S_IDLE ? (grant == OP_NONE ? S_IDLE : pre_fail ? S_CAPTURE : S_ISSUE) :
                   state == S_ISSUE ? S_CAPTURE :
                   state == S_CAPTURE ? (code != FC_NONE ? S_FAULT : S_IDLE) :
                   Fault_Clr ? S_IDLE : S_FAULT;
    end

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) begin
            Stack_Enable <= 1'b0;
            Stack_Write  <= 1'b0;
            NPPC         <= '0;
            Call_Ack     <= 1'b0;
            Ret_Ack      <= 1'b0;
            Irq_Ack      <= 1'b0;
            Op_Err       <= 1'b0;
            Jump_Valid   <= 1'b0;
            Jump_Addr    <= '0;
            Depth        <= '0;
            Irq_Active   <= 1'b0;
            code         <= FC_NONE;
            op           <= OP_NONE;
            iret_q       <= 1'b0;
            ret_q        <= '0;
        end else begin
            Stack_Enable <= grant != OP_NONE && !pre_fail;
            Stack_Write  <= is_push(grant) && !pre_fail;
            Call_Ack     <= state == S_CAPTURE && op == OP_CALL;
            Ret_Ack      <= state == S_CAPTURE && op == OP_RET;
            Irq_Ack      <= state == S_CAPTURE && op == OP_IRQ;
            Op_Err       <= state == S_CAPTURE && code != FC_NONE;
            Jump_Valid   <= ok && op != OP_CALL;
            if (grant != OP_NONE) begin
                op     <= grant;
                iret_q <= ret_iret;
                if (pre_fail) code <= is_push(grant) ? FC_OVF : FC_UNF;
            end
            if (grant == OP_CALL) NPPC <= call_addr;
            else if (grant == OP_IRQ) NPPC <= irq_addr;
            // The stack has acted on the negedge inside ISSUE; its verdict is final here.
            if (state == S_ISSUE) begin
                ret_q <= Ret_Add;
                if (Err_Out) code <= FC_DESYNC;
            end
            if (ok) begin
                Depth <= is_push(op) ? Depth + 10'd1 : Depth - 10'd1;
                if (op != OP_CALL) Jump_Addr <= op == OP_IRQ ? IRQ_VECTOR : ret_q;
                if (op == OP_IRQ) Irq_Active <= 1'b1;
                else if (op == OP_RET && iret_q) Irq_Active <= 1'b0;
            end
            if (state == S_FAULT && Fault_Clr) code <= FC_NONE;
        end
    end
endmodule

// File: tb/tb_stack_call_ctrl.sv
// tb_stack_call_ctrl: directed and random checks of stack_call_ctrl against a
// transaction-level model (a queue standing in for the return stack).
module tb_stack_call_ctrl;
    logic        Slow_Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Call_Req = 1'b0, Ret_Req = 1'b0, Ret_Is_Iret = 1'b0, Irq_Req = 1'b0, Fault_Clr = 1'b0;
    logic [12:0] Call_NPPC = '0, Irq_PC = '0;
    logic        Stack_Enable, Stack_Write, Call_Ack, Ret_Ack, Irq_Ack, Op_Err, Jump_Valid;
    logic        Irq_Active, Busy, Fault;
    logic [12:0] NPPC, Jump_Addr;
    logic [12:0] Ret_Add = '0;
    logic        Err_Out = 1'b0;
    logic [9:0]  Depth;
    logic [1:0]  Fault_Code;

    int errors = 0, checks = 0;
    int se_count = 0;
    bit force_err = 0;
    logic [12:0] mem [0:1023];
    int sp = 0;
    logic [12:0] ref_q[$];
    bit ref_act = 0;

    stack_call_ctrl dut (
        .Slow_Clock(Slow_Clock), .Reset(Reset), .Call_Req(Call_Req), .Call_NPPC(Call_NPPC),
        .Ret_Req(Ret_Req), .Ret_Is_Iret(Ret_Is_Iret), .Irq_Req(Irq_Req), .Irq_PC(Irq_PC),
        .Fault_Clr(Fault_Clr), .Stack_Enable(Stack_Enable), .Stack_Write(Stack_Write), .NPPC(NPPC),
        .Ret_Add(Ret_Add), .Err_Out(Err_Out), .Call_Ack(Call_Ack), .Ret_Ack(Ret_Ack), .Irq_Ack(Irq_Ack),
        .Op_Err(Op_Err), .Jump_Valid(Jump_Valid), .Jump_Addr(Jump_Addr), .Depth(Depth),
        .Irq_Active(Irq_Active), .Busy(Busy), .Fault(Fault), .Fault_Code(Fault_Code)
    );

    always #5 Slow_Clock = ~Slow_Clock;

    // Stand-in for StackFile: acts on the falling edge, 1023-entry limit.
    always @(negedge Slow_Clock) begin
        if (!Reset) begin
            sp <= 0;
            Err_Out <= 1'b0;
            Ret_Add <= '0;
        end else if (Stack_Enable) begin
            se_count <= se_count + 1;
            if (Stack_Write) begin
                if (force_err || sp >= 1023) Err_Out <= 1'b1;
                else begin
                    mem[sp] <= NPPC;
                    sp <= sp + 1;
                    Err_Out <= 1'b0;
                end
            end else begin
                if (force_err || sp == 0) Err_Out <= 1'b1;
                else begin
                    Ret_Add <= mem[sp-1];
                    sp <= sp - 1;
                    Err_Out <= 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Slow_Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_call(input logic [12:0] a);
        Call_NPPC = a; Call_Req = 1'b1;
        tick();
        Call_Req = 1'b0;
    endtask

    task automatic pulse_ret(input bit iret);
        Ret_Is_Iret = iret; Ret_Req = 1'b1;
        tick();
        Ret_Req = 1'b0;
    endtask

    task automatic pulse_irq(input logic [12:0] pc);
        Irq_PC = pc; Irq_Req = 1'b1;
        tick();
        Irq_Req = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(Call_Ack || Ret_Ack || Irq_Ack) && n < 20);
    endtask

    // op: 0 call, 1 ret, 2 irq. skip = cycles already consumed since the request edge.
    task automatic expect_op(input int op, input logic [12:0] d, input bit iret, input int skip);
        int n;
        logic [1:0] code;
        bit jv;
        logic [12:0] ja;
        logic [2:0] ea;
        code = 2'b00; jv = 0; ja = '0;
        ea = op == 0 ? 3'b100 : op == 1 ? 3'b010 : 3'b001;
        if (op != 1) begin
            if (ref_q.size() == 1023) code = 2'b01;
            else if (force_err) code = 2'b11;
            else begin
                ref_q.push_back(d);
                if (op == 2) begin
                    jv = 1; ja = 13'h0010; ref_act = 1;
                end
            end
        end else begin
            if (ref_q.size() == 0) code = 2'b10;
            else if (force_err) code = 2'b11;
            else begin
                ja = ref_q.pop_back();
                jv = 1;
                if (iret) ref_act = 0;
            end
        end
        wait_ack(n);
        chk("latency", n + skip, (code == 2'b01 || code == 2'b10) ? 2 : 3);
        chk("ack", {Call_Ack, Ret_Ack, Irq_Ack}, ea);
        chk("op_err", Op_Err, code != 2'b00);
        chk("jump_valid", Jump_Valid, jv);
        if (jv) chk("jump_addr", Jump_Addr, ja);
        chk("depth", Depth, ref_q.size());
        chk("irq_active", Irq_Active, ref_act);
        chk("fault", Fault, code != 2'b00);
        chk("fault_code", Fault_Code, code);
        if (code != 2'b00) begin
            Fault_Clr = 1'b1;
            tick();
            Fault_Clr = 1'b0;
            chk("fault_clr", {Fault, Fault_Code}, 0);
        end
    endtask

    initial begin
        int snap, acks, op;
        logic [12:0] d;
        bit iret;
        repeat (3) tick();
        chk("reset_a", {Stack_Enable, Stack_Write, NPPC, Call_Ack, Ret_Ack, Irq_Ack, Op_Err, Jump_Valid}, 0);
        chk("reset_b", {Jump_Addr, Depth, Irq_Active, Busy, Fault, Fault_Code}, 0);
        Reset = 1'b1;
        tick();

        pulse_call(13'h0123);
        tick();
        chk("push_drive", {Stack_Enable, Stack_Write, NPPC}, {2'b11, 13'h0123});
        expect_op(0, 13'h0123, 0, 1);
        pulse_ret(0);
        tick();
        chk("pop_drive", {Stack_Enable, Stack_Write}, 2'b10);
        expect_op(1, '0, 0, 1);

        Irq_PC = 13'h0456; Call_NPPC = 13'h0222; Ret_Is_Iret = 1'b0;
        Irq_Req = 1'b1; Call_Req = 1'b1; Ret_Req = 1'b1;
        tick();
        Irq_Req = 1'b0; Call_Req = 1'b0; Ret_Req = 1'b0;
        expect_op(2, 13'h0456, 0, 0);
        expect_op(0, 13'h0222, 0, 0);
        expect_op(1, '0, 0, 0);

        snap = se_count;
        pulse_irq(13'h0777);
        repeat (5) tick();
        chk("irq_masked_drive", se_count, snap);
        chk("irq_masked_busy", {Busy, Irq_Ack}, 2'b10);
        pulse_ret(1);
        expect_op(1, '0, 1, 0);
        expect_op(2, 13'h0777, 0, 0);
        pulse_ret(1);
        expect_op(1, '0, 1, 0);

        snap = se_count;
        pulse_ret(0);
        expect_op(1, '0, 0, 0);
        chk("underflow_no_drive", se_count, snap);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 2);
            iret = 1'($urandom_range(0, 1));
            d = 13'($urandom);
            if (op == 2 && ref_act) begin
                op = 1; iret = 1;
            end
            repeat ($urandom_range(0, 2)) tick();
            if (op == 0) pulse_call(d);
            else if (op == 1) pulse_ret(iret);
            else pulse_irq(d);
            expect_op(op, d, iret, 0);
        end

        while (ref_q.size() < 1023) begin
            d = 13'($urandom);
            pulse_call(d);
            expect_op(0, d, 0, 0);
        end
        snap = se_count;
        pulse_call(13'h1fff);
        expect_op(0, 13'h1fff, 0, 0);
        chk("overflow_no_drive", se_count, snap);

        pulse_ret(0);
        expect_op(1, '0, 0, 0);
        force_err = 1;
        pulse_call(13'h01aa);
        expect_op(0, 13'h01aa, 0, 0);
        force_err = 0;

        pulse_call(13'h0abc);
        tick();
        chk("issue_before_reset", Stack_Enable, 1'b1);
        Reset = 1'b0;
        #1;
        chk("async_reset_a", {Stack_Enable, Stack_Write, NPPC, Call_Ack, Ret_Ack, Irq_Ack, Op_Err, Jump_Valid}, 0);
        chk("async_reset_b", {Jump_Addr, Depth, Irq_Active, Busy, Fault, Fault_Code}, 0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(Call_Ack || Ret_Ack || Irq_Ack);
        end
        chk("no_ack_in_reset", acks, 0);
        Reset = 1'b1;
        ref_q.delete();
        ref_act = 0;
        tick();
        pulse_call(13'h0abc);
        expect_op(0, 13'h0abc, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_call_ctrl.md
Name: stack_call_ctrl

Overview:
- Sequencer and arbiter in front of the 13-bit return-address stack (StackFile).
- Accepts call, return and interrupt-entry requests from the control unit and serialises them into single stack push/pop operations.
- Tracks a shadow depth so overflow and underflow are detected before the stack is driven.
- Reports faults and delivers return and vector addresses to PC logic.

Parameters:
ADDR_W, 13, width of PC, NPPC and return addresses
DEPTH_MAX, 1023, maximum number of stacked entries (the stack's pointer limit)
IRQ_VECTOR, 13'h0010, jump target issued on interrupt entry

Ports:
Slow_Clock  in  1  system clock; all state updates on posedge
Reset  in  1  asynchronous, active-low (0 = reset)
Call_Req  in  1  one-cycle pulse: push Call_NPPC
Call_NPPC  in  ADDR_W  return address for a call; sampled with Call_Req
Ret_Req  in  1  one-cycle pulse: pop
Ret_Is_Iret  in  1  sampled with Ret_Req; marks return-from-interrupt
Irq_Req  in  1  one-cycle pulse: push Irq_PC and vector
Irq_PC  in  ADDR_W  interrupted PC; sampled with Irq_Req
Fault_Clr  in  1  leaves FAULT state
Stack_Enable  out  1  to stack
Stack_Write  out  1  to stack; 1 = push, 0 = pop
NPPC  out  ADDR_W  to stack; push data
Ret_Add  in  ADDR_W  from stack; popped address
Err_Out  in  1  from stack
Call_Ack, Ret_Ack, Irq_Ack  out  1 each  one-cycle completion pulses
Op_Err  out  1  qualifies an Ack pulse: the operation failed
Jump_Valid  out  1  pulse; Jump_Addr valid
Jump_Addr  out  ADDR_W  popped address (return) or IRQ_VECTOR (irq)
Depth  out  10  shadow entry count
Irq_Active  out  1  inside interrupt handler
Busy  out  1  state != IDLE or any request pending
Fault  out  1  FAULT state
Fault_Code  out  2  00 none, 01 overflow, 10 underflow, 11 desync

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE; pending flags, latched operands, Depth, Irq_Active and all outputs = 0.
  - Fault_Code=00.
  - Reset mid-operation aborts it with no Ack.
  - The top level resets the stack from the same net (inverted), so Depth=0 stays consistent with the stack.
- Request capture:
  - Each *_Req pulse sets its pending flag and latches its operand.
  - A pulse whose class is already pending is ignored, including in the cycle that class is granted.
- Arbitration in IDLE, when any flag is pending and eligible:
  - Priority is Irq > Call > Ret.
  - Irq is ineligible while Irq_Active=1; it stays pending.
  - Granting clears the flag.
- FSM states: IDLE, ISSUE, CAPTURE, FAULT.
- IDLE → ISSUE (normal grant):
  - Registered Stack_Enable=1 and Stack_Write=1 for push, 0 for pop.
  - NPPC = Call_NPPC or Irq_PC.
  - The stack acts on the negedge inside ISSUE.
- IDLE → CAPTURE (pre-check fails, stack not driven):
  - Push with Depth==DEPTH_MAX: Fault_Code=01.
  - Pop with Depth==0: Fault_Code=10.
- ISSUE → CAPTURE:
  - Stack_Enable=0.
  - Sample Err_Out and Ret_Add.
  - Err_Out=1 without a pre-check failure gives Fault_Code=11.
- CAPTURE, one cycle:
  - Pulse the granted class Ack; Op_Err=1 if faulted.
  - On success:
    - Push: Depth+1.
    - Pop: Depth−1.
    - Ret: Jump_Valid=1, Jump_Addr=Ret_Add; if Iret, clear Irq_Active.
    - Irq: Jump_Valid=1, Jump_Addr=IRQ_VECTOR; set Irq_Active.
  - Next state: FAULT if faulted, else IDLE.
- FAULT:
  - No grants; pulses are still captured.
  - Fault_Clr=1 → IDLE, clearing Fault, Fault_Code and all pending flags.
  - Depth is unchanged.
- Latency and throughput:
  - Request pulse at edge T0 is pending at T0; grant at the first IDLE edge T1.
  - Ack is high in the cycle after edge T3.
  - Max throughput is one op per 3 cycles.
- Depth never wraps; it saturates via the pre-checks.

Decomposition:
- Shared package holds:
  - ADDR_W and DEPTH_MAX.
  - Fault_Code encodings.
  - FSM state encodings.
  - Op-class encoding (OP_CALL, OP_RET, OP_IRQ).
- One sub-module: stack_req_arbiter (pending flags, operand latches, fixed-priority grant with Irq eligibility mask).
- FSM and depth tracking stay in the top.

Test Plan:
- Call_Req with Call_NPPC=0x0123, then Ret_Req → Stack_Enable/Write=1/1 with NPPC=0x0123, then 1/0; Ret_Ack with Jump_Addr=0x0123; Depth 0→1→0.
- Irq_Req (Irq_PC=0x0456), Call_Req and Ret_Req in the same cycle → grant order Irq (Jump_Addr=0x0010, Irq_Active=1), Call, Ret; three Acks, each 3 cycles apart.
- Irq_Req while Irq_Active=1 → no grant; Ret_Req with Ret_Is_Iret=1 → Irq_Active=0; the pending Irq is granted next.
- Ret_Req at Depth=0 → no Stack_Enable; Ret_Ack with Op_Err=1; Fault=1, Fault_Code=10; Fault_Clr → IDLE.
- 1023 calls then a 1024th → Depth=1023, Fault_Code=01, stack not driven; stack model forcing Err_Out=1 on a normal push → Fault_Code=11.
- Reset low during ISSUE → all outputs 0 asynchronously, no Ack; after release a Call completes normally with Depth=1.
